lamp_safety_monitor: RTL and testbench

- Sits directly downstream of the 8-lane traffic light controller.
- Consumes the controller's per-lane lamp codes T1..T8 and checks them every cycle for conflicting greens, illegal codes and illegal transitions.
- Translates the codes into physical one-hot {R,Y,G} lamp drives.
- On any violation, latches a fault and forces all lanes to a flashing fail-safe pattern until cleared.

---
 rtl/lamp_safety_monitor_if.sv | 20 ++
 rtl/lamp_safety_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_lamp_safety_monitor.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lamp_safety_monitor_if.sv
// Lamp-side bus between the 8-lane traffic controller and lamp_safety_monitor.
// The master modport is the controller/bench side; the slave modport is the monitor.
interface lamp_safety_monitor_if;
  logic       clear;
  logic [2:0] T1, T2, T3, T4, T5, T6, T7, T8;
  logic [2:0] L1, L2, L3, L4, L5, L6, L7, L8;
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] fault_lane;

  modport master (
    output clear, T1, T2, T3, T4, T5, T6, T7, T8,
    input  L1, L2, L3, L4, L5, L6, L7, L8, fault, fault_code, fault_lane
  );

  modport slave (
    input  clear, T1, T2, T3, T4, T5, T6, T7, T8,
    output L1, L2, L3, L4, L5, L6, L7, L8, fault, fault_code, fault_lane
  );
endinterface

// File: rtl/lamp_safety_monitor.sv
// Checks controller lamp codes each cycle, drives one-hot {R,Y,G} lamps, latches a flashing fail-safe.
// Define STALL_WDOG_EN to include the input-stall watchdog (fault code 6).
module lamp_safety_monitor #(
  parameter int MIN_YELLOW     = 4,
  parameter int MAX_STABLE     = 32,
  parameter int STARTUP_CYCLES = 3,
  parameter int FLASH_HALF     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  lamp_safety_monitor_if.slave  bus
);
  localparam logic [2:0] T_RED = 3'b000, T_GRN = 3'b100, T_YEL = 3'b010;
  localparam logic [2:0] L_RED = 3'b100, L_YEL = 3'b010, L_GRN = 3'b001;
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int IW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [YW-1:0] YEL_SAT    = YW'(MIN_YELLOW);
  localparam logic [IW-1:0] INIT_LAST  = IW'(STARTUP_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_e;
  typedef enum logic [2:0] {
    FC_NONE = 3'd0, FC_ILLEGAL = 3'd1, FC_CONFLICT = 3'd2, FC_SKIP = 3'd3,
    FC_SHORT_YEL = 3'd4, FC_REVERSE = 3'd5, FC_STALL = 3'd6
  } fault_code_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            init_cnt_q, init_cnt_d;
  logic [FW-1:0]            flash_cnt_q, flash_cnt_d;
  logic                     flash_on_q, flash_on_d;
  logic [7:0][2:0]          hist_q, hist_d;
  logic [7:0][YW-1:0]       yel_cnt_q, yel_cnt_d;
  logic [7:0][2:0]          l_q, l_d;
  fault_code_e              code_q, code_d;
  logic [2:0]               lane_q, lane_d;

  logic [7:0][2:0] t;
  fault_code_e     viol_code;
  logic [2:0]      viol_lane;
  logic            stall_hit;

  assign t = {bus.T8, bus.T7, bus.T6, bus.T5, bus.T4, bus.T3, bus.T2, bus.T1};
  assign {bus.L8, bus.L7, bus.L6, bus.L5, bus.L4, bus.L3, bus.L2, bus.L1} = l_q;
  assign bus.fault      = (state_q == ST_FAULT);
  assign bus.fault_code = code_q;
  assign bus.fault_lane = lane_q;

  function automatic logic [2:0] xlate(input logic [2:0] c);
    case (c)
      T_GRN:   return L_GRN;
      T_YEL:   return L_YEL;
      default: return L_RED;
    endcase
  endfunction

`ifdef STALL_WDOG_EN
  localparam int SW = $clog2(MAX_STABLE + 1);
  localparam logic [SW-1:0] STAB_SAT  = SW'(MAX_STABLE);
  localparam logic [SW-1:0] STAB_LAST = SW'(MAX_STABLE - 1);
  logic [SW-1:0] stab_q, stab_d;

  always_comb begin
    stab_d = '0;
    if (state_q == ST_RUN && t == hist_q)
      stab_d = (stab_q == STAB_SAT) ? STAB_SAT : stab_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) stab_q <= '0;
    else        stab_q <= stab_d;
  end

  assign stall_hit = (state_q == ST_RUN) && (t == hist_q) && (stab_q == STAB_LAST);
`else
  assign stall_hit = 1'b0;
`endif

  // Lane scans run high-to-low so the lowest offending lane is the one kept.
  always_comb begin
    logic       ill_hit, skip_hit, short_hit, rev_hit, conflict;
    logic [2:0] ill_lane, skip_lane, short_lane, rev_lane;
    logic [3:0] pair_act, pair_split;
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    ill_hit = 1'b0;  skip_hit = 1'b0;  short_hit = 1'b0;  rev_hit = 1'b0;
    ill_lane = '0;   skip_lane = '0;   short_lane = '0;   rev_lane = '0;
    pair_act = '0;   pair_split = '0;
    viol_code = FC_NONE;
    viol_lane = '0;
    for (int i = 7; i >= 0; i--) begin
      if (t[i] != T_RED && t[i] != T_GRN && t[i] != T_YEL) begin
        ill_hit = 1'b1; ill_lane = 3'(i);
      end
      if (hist_q[i] == T_GRN && t[i] == T_RED) begin
        skip_hit = 1'b1; skip_lane = 3'(i);
      end
      if (hist_q[i] == T_YEL && t[i] == T_RED && yel_cnt_q[i] < YEL_SAT) begin
        short_hit = 1'b1; short_lane = 3'(i);
      end
      if ((hist_q[i] == T_RED && t[i] == T_YEL) || (hist_q[i] == T_YEL && t[i] == T_GRN)) begin
        rev_hit = 1'b1; rev_lane = 3'(i);
      end
    end
    for (int p = 0; p < 4; p++) begin
      pair_act[p]   = (t[p] != T_RED) || (t[p+4] != T_RED);
      pair_split[p] = pair_act[p] && (t[p] != t[p+4]);
    end
    conflict = (|pair_split) || ((pair_act & (pair_act - 4'd1)) != 4'd0);

    if (ill_hit)        begin viol_code = FC_ILLEGAL;   viol_lane = ill_lane;   end
    else if (conflict)  begin viol_code = FC_CONFLICT;  viol_lane = '0;         end
    else if (skip_hit)  begin viol_code = FC_SKIP;      viol_lane = skip_lane;  end
    else if (short_hit) begin viol_code = FC_SHORT_YEL; viol_lane = short_lane; end
    else if (rev_hit)   begin viol_code = FC_REVERSE;   viol_lane = rev_lane;   end
    else if (stall_hit) begin viol_code = FC_STALL;     viol_lane = '0;         end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    flash_cnt_d = flash_cnt_q;
    flash_on_d  = flash_on_q;
    hist_d      = hist_q;
    yel_cnt_d   = yel_cnt_q;
    l_d         = l_q;
    code_d      = code_q;
    lane_d      = lane_q;
    case (state_q)
      ST_INIT: begin
        l_d = {8{L_RED}};
        for (int i = 0; i < 8; i++) yel_cnt_d[i] = (t[i] == T_YEL) ? YW'(1) : '0;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
          hist_d     = t;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      ST_RUN: begin
        if (viol_code != FC_NONE) begin
          // The offending code never reaches the lamps: the first fault cycle already flashes.
          state_d     = ST_FAULT;
          code_d      = viol_code;
          lane_d      = viol_lane;
          flash_cnt_d = '0;
          flash_on_d  = 1'b1;
          l_d         = {8{L_YEL}};
        end else begin
          hist_d = t;
          for (int i = 0; i < 8; i++) begin
            l_d[i]       = xlate(t[i]);
            yel_cnt_d[i] = (t[i] != T_YEL)           ? '0 :
                           (yel_cnt_q[i] == YEL_SAT) ? YEL_SAT : yel_cnt_q[i] + YW'(1);
          end
        end
      end
      ST_FAULT: begin
        if (bus.clear) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
          code_d     = FC_NONE;
          lane_d     = '0;
          l_d        = {8{L_RED}};
        end else begin
          if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_d = '0;
            flash_on_d  = ~flash_on_q;
          end else begin
            flash_cnt_d = flash_cnt_q + FW'(1);
          end
          l_d = flash_on_d ? {8{L_YEL}} : '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the per-lane history and counter arrays are small flop banks that the checks read, so they are reset like any other state.
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b0;
      hist_q      <= {8{T_RED}};
      yel_cnt_q   <= '0;
      l_q         <= {8{L_RED}};
      code_q      <= FC_NONE;
      lane_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      hist_q      <= hist_d;
      yel_cnt_q   <= yel_cnt_d;
      l_q         <= l_d;
      code_q      <= code_d;
      lane_q      <= lane_d;
    end
  end
endmodule

// File: tb/tb_lamp_safety_monitor.sv
// Directed bench for lamp_safety_monitor: a vector table for the legal cycle and conflict flash,
// plus hand-written sequences for recovery, yellow timing, priority, reset/clear and the stall watchdog.
module tb_lamp_safety_monitor;
  localparam logic [2:0] C_R = 3'b000, C_G = 3'b100, C_Y = 3'b010, C_BAD = 3'b111;
  localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001, L_D = 3'b000;

  typedef logic [7:0][2:0] bank_t;
  typedef struct {
    bank_t      t;
    bank_t      l;
    logic       flt;
    logic [2:0] code;
    logic [2:0] lane;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  clr;
  bank_t tv;
  bank_t l_act;
  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  tbl[$];

  lamp_safety_monitor_if bus ();

  assign bus.clear = clr;
  assign {bus.T8, bus.T7, bus.T6, bus.T5, bus.T4, bus.T3, bus.T2, bus.T1} = tv;
  assign l_act = {bus.L8, bus.L7, bus.L6, bus.L5, bus.L4, bus.L3, bus.L2, bus.L1};

  lamp_safety_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bank_t lanes(input logic [2:0] dflt, input logic [7:0] m, input logic [2:0] v);
    bank_t r;
    for (int i = 0; i < 8; i++) r[i] = m[i] ? v : dflt;
    return r;
  endfunction

  task automatic add(input bank_t t, input bank_t l, input logic f, input logic [2:0] code);
    vec_t v;
    v.t = t; v.l = l; v.flt = f; v.code = code; v.lane = 3'd0;
    tbl.push_back(v);
  endtask

  task automatic expect_idle(input string name, input bank_t l);
    check({name, "_L"}, l_act, l);
    check({name, "_fault"}, bus.fault, 1'b0);
    check({name, "_code"}, bus.fault_code, 3'd0);
  endtask

  task automatic expect_fault(input string name, input logic [2:0] code, input logic [2:0] lane);
    check({name, "_fault"}, bus.fault, 1'b1);
    check({name, "_code"}, bus.fault_code, code);
    check({name, "_lane"}, bus.fault_lane, lane);
    check({name, "_L"}, l_act, {8{L_Y}});
  endtask

  // Clear pulse in FAULT, then the three INIT cycles; leaves the DUT in RUN with all-red history.
  task automatic do_clear(input string name);
    tv  = {8{C_R}};
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_idle({name, "_c0"}, {8{L_R}});
    check({name, "_lane0"}, bus.fault_lane, 3'd0);
    tick();
    expect_idle({name, "_c1"}, {8{L_R}});
    tick();
    expect_idle({name, "_c2"}, {8{L_R}});
    tick();
  endtask

  initial begin
    reset = 1'b0;
    clr   = 1'b0;
    tv    = {8{C_R}};
    tick();
    tick();
    expect_idle("reset", {8{L_R}});
    check("reset_lane", bus.fault_lane, 3'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle($sformatf("init%0d", i), {8{L_R}});
    end

    // Legal cycle on pair {T4,T8}, hand-off to {T3,T7}, then a conflict and its flash pattern.
    for (int i = 0; i < 9; i++) add(lanes(C_R, 8'h88, C_G), lanes(L_R, 8'h88, L_G), 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) add(lanes(C_R, 8'h88, C_Y), lanes(L_R, 8'h88, L_Y), 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) add(lanes(C_R, 8'h44, C_G), lanes(L_R, 8'h44, L_G), 1'b0, 3'd0);
    add(lanes(C_R, 8'hCC, C_G), {8{L_Y}}, 1'b1, 3'd2);
    add(lanes(C_R, 8'hCC, C_G), {8{L_Y}}, 1'b1, 3'd2);
    add(lanes(C_R, 8'hCC, C_G), {8{L_D}}, 1'b1, 3'd2);
    add(lanes(C_R, 8'hCC, C_G), {8{L_D}}, 1'b1, 3'd2);
    add(lanes(C_R, 8'hCC, C_G), {8{L_Y}}, 1'b1, 3'd2);
    add(lanes(C_R, 8'hCC, C_G), {8{L_Y}}, 1'b1, 3'd2);
    add(lanes(C_R, 8'hCC, C_G), {8{L_D}}, 1'b1, 3'd2);

    foreach (tbl[k]) begin
      tv = tbl[k].t;
      tick();
      check($sformatf("vec%0d_L", k), l_act, tbl[k].l);
      check($sformatf("vec%0d_fault", k), bus.fault, tbl[k].flt);
      check($sformatf("vec%0d_code", k), bus.fault_code, tbl[k].code);
      check($sformatf("vec%0d_lane", k), bus.fault_lane, tbl[k].lane);
    end

    // Recovery to RUN, then clear while running must be ignored.
    do_clear("clear1");
    tv = lanes(C_R, 8'h11, C_G);
    tick();
    expect_idle("run_after_clear", lanes(L_R, 8'h11, L_G));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_idle("clear_in_run", lanes(L_R, 8'h11, L_G));

    // Exactly MIN_YELLOW yellow cycles is legal.
    tv = lanes(C_R, 8'h11, C_Y);
    for (int i = 0; i < 4; i++) tick();
    expect_idle("yel4_L", lanes(L_R, 8'h11, L_Y));
    tv = {8{C_R}};
    tick();
    expect_idle("yel4_red", {8{L_R}});

    // Short yellow on {T2,T6}: two yellow cycles then red.
    tv = lanes(C_R, 8'h22, C_G);
    tick();
    tv = lanes(C_R, 8'h22, C_Y);
    tick();
    tick();
    tv = {8{C_R}};
    tick();
    expect_fault("short_yel", 3'd4, 3'd1);

    do_clear("clear2");
    tv = lanes(C_R, 8'h11, C_G);
    tick();
    tv = {8{C_R}};
    tick();
    expect_fault("skip", 3'd3, 3'd0);

    // Illegal code on T5 outranks the simultaneous skip on T1.
    do_clear("clear3");
    tv = lanes(C_R, 8'h11, C_G);
    tick();
    tv = lanes(C_R, 8'h10, C_BAD);
    tick();
    expect_fault("priority", 3'd1, 3'd4);

    do_clear("clear4");
    tv = lanes(C_R, 8'h44, C_Y);
    tick();
    expect_fault("reverse", 3'd5, 3'd2);

    // Reset and clear together: reset wins and INIT restarts.
    reset = 1'b0;
    clr   = 1'b1;
    tv    = {8{C_R}};
    tick();
    expect_idle("rst_clr", {8{L_R}});
    check("rst_clr_lane", bus.fault_lane, 3'd0);
    reset = 1'b1;
    clr   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle($sformatf("rst_init%0d", i), {8{L_R}});
    end

    tv = lanes(C_R, 8'h11, C_G);
    tick();
    expect_idle("stall_start", lanes(L_R, 8'h11, L_G));
`ifdef STALL_WDOG_EN
    begin
      logic early = 1'b0;
      for (int i = 0; i < 31; i++) begin
        tick();
        if (bus.fault) early = 1'b1;
      end
      check("stall_not_early", early, 1'b0);
      tick();
      check("stall_fault", bus.fault, 1'b1);
      check("stall_code", bus.fault_code, 3'd6);
      check("stall_lane", bus.fault_lane, 3'd0);
    end
`else
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (bus.fault) seen = 1'b1;
      end
      check("no_stall", seen, 1'b0);
      expect_idle("no_stall_end", lanes(L_R, 8'h11, L_G));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
